// File: rtl/rf_pkg.sv
// Shared register-file constants and types for the write-port arbiter slice.
// Build option: define RF_WARB_RR_EN for round-robin arbitration; fixed priority otherwise.
package rf_pkg;

  localparam int XLEN     = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef logic [ADDR_W-1:0] rf_addr_t;
  typedef logic [XLEN-1:0]   xlen_t;

endpackage

// File: rtl/rf_rr_arbiter.sv
// One-hot grant generator for the register-file write port.
// RF_WARB_RR_EN defined: round-robin arbitration with a rotating start pointer.
// RF_WARB_RR_EN undefined: fixed priority, requester 0 highest, no state.
module rf_rr_arbiter #(
  parameter int NUM_REQ = 3
) (
`ifdef RF_WARB_RR_EN
  input  logic               clk_i,
  input  logic               rst_i,
`endif
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] grant_o
);

`ifdef RF_WARB_RR_EN
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // Search from the pointer for the first valid requester; the pointer moves past the winner.
  always_comb begin
    int  idx;
    logic found;
    // NOTE: every output gets a default before any condition, so no path leaves it unassigned (no latch).
    grant_o = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = 0;
    if (en_i) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = int'(ptr_q) + i;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!found && req_i[idx]) begin
          found        = 1'b1;
          grant_o[idx] = 1'b1;
          ptr_d        = (idx == NUM_REQ - 1) ? '0 : PTR_W'(idx + 1);
        end
      end
    end
  end

  // Priority pointer register; it only changes when a grant was issued.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  // Fixed priority: scan from the highest index down so the lowest valid index wins.
  always_comb begin
    grant_o = '0;
    if (en_i) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (req_i[i]) begin
          grant_o    = '0;
          grant_o[i] = 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between NUM_REQ writeback sources.
// The winning request is registered onto the write port (one-cycle latency), and a
// pending-write scoreboard tracks in-flight destinations for RAW hazard detection.
// Build option: define RF_WARB_RR_EN for round-robin grants; fixed priority otherwise.
module rf_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 64,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*XLEN-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic                      issue_valid_i,
  input  logic [ADDR_W-1:0]         issue_addr_i,
  input  logic                      flush_i,
  output logic                      rf_write_en_o,
  output logic [ADDR_W-1:0]         rf_write_addr_o,
  output logic [XLEN-1:0]           rf_write_data_o,
  output logic [rf_pkg::NUM_REGS-1:0] pending_o
);

  import rf_pkg::*;

  logic [NUM_REQ-1:0]  grant;
  logic                arb_en;
  logic                win_valid;
  logic [ADDR_W-1:0]   win_addr;
  logic [XLEN-1:0]     win_data;
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  // No grants during flush or while reset is held, so no handshake can be lost.
  assign arb_en = !flush_i && !rst_i;

  rf_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
`ifdef RF_WARB_RR_EN
    .clk_i   (clk_i),
    .rst_i   (rst_i),
`endif
    .req_i   (req_valid_i),
    .en_i    (arb_en),
    .grant_o (grant)
  );

  assign req_ready_o = grant;
  assign win_valid   = |grant;

  // Select the granted requester's address and data (grant is one-hot).
  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        win_addr = req_addr_i[k*ADDR_W +: ADDR_W];
        win_data = req_data_i[k*XLEN +: XLEN];
      end
    end
  end

  // Write-port register: x0 writes are consumed but never enabled; address/data hold otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rf_write_en_o   <= 1'b0;
      rf_write_addr_o <= '0;
      rf_write_data_o <= '0;
    end else begin
      rf_write_en_o <= win_valid && (win_addr != '0);
      if (win_valid && (win_addr != '0)) begin
        rf_write_addr_o <= win_addr;
        rf_write_data_o <= win_data;
      end
    end
  end

  // Scoreboard next state: commit clears, issue sets (set wins), flush clears everything.
  always_comb begin
    pending_d = pending_q;
    if (flush_i) begin
      pending_d = '0;
    end else begin
      if (rf_write_en_o) pending_d[rf_write_addr_o] = 1'b0;
      if (issue_valid_i && (issue_addr_i != '0)) pending_d[issue_addr_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: the scoreboard is a flop vector rather than a RAM, so clearing it on reset is legal and cheap.
    if (rst_i) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  assign pending_o = pending_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: a reference model predicts the grant each
// cycle, pushes the expected write-port contents to a queue, and pops/compares them
// after the clock edge. Also tracks the expected scoreboard contents.
module tb_rf_write_arbiter;

  localparam int NUM_REQ = 3;
  localparam int XLEN    = 64;
  localparam int ADDR_W  = 5;

  typedef struct {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   data;
  } wr_t;

  logic                      clk_i;
  logic                      rst_i;
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ*XLEN-1:0]   req_data_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic                      issue_valid_i;
  logic [ADDR_W-1:0]         issue_addr_i;
  logic                      flush_i;
  logic                      rf_write_en_o;
  logic [ADDR_W-1:0]         rf_write_addr_o;
  logic [XLEN-1:0]           rf_write_data_o;
  logic [31:0]               pending_o;

  // Requester-side state, packed onto the DUT buses.
  logic              v [NUM_REQ];
  logic [ADDR_W-1:0] a [NUM_REQ];
  logic [XLEN-1:0]   d [NUM_REQ];

  // Model state.
  wr_t         exp_q[$];
  logic [31:0] m_pend;
  logic        m_out_en;
  logic [ADDR_W-1:0] m_out_addr;
`ifdef RF_WARB_RR_EN
  int          m_ptr;
`endif

  int n_checks;
  int n_errors;

  rf_write_arbiter #(
    .NUM_REQ (NUM_REQ),
    .XLEN    (XLEN),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .req_valid_i     (req_valid_i),
    .req_addr_i      (req_addr_i),
    .req_data_i      (req_data_i),
    .req_ready_o     (req_ready_o),
    .issue_valid_i   (issue_valid_i),
    .issue_addr_i    (issue_addr_i),
    .flush_i         (flush_i),
    .rf_write_en_o   (rf_write_en_o),
    .rf_write_addr_o (rf_write_addr_o),
    .rf_write_data_o (rf_write_data_o),
    .pending_o       (pending_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      req_valid_i[k]                   = v[k];
      req_addr_i[k*ADDR_W +: ADDR_W]   = a[k];
      req_data_i[k*XLEN +: XLEN]       = d[k];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference arbitration from the bench's own view of requests and pointer.
  function automatic logic [NUM_REQ-1:0] model_grant();
    logic [NUM_REQ-1:0] g;
    g = '0;
    if (rst_i || flush_i) return g;
`ifdef RF_WARB_RR_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      int k;
      k = (m_ptr + i) % NUM_REQ;
      if (v[k]) begin
        g[k] = 1'b1;
        return g;
      end
    end
`else
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v[i]) begin
        g[i] = 1'b1;
        return g;
      end
    end
`endif
    return g;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pend     = '0;
    m_out_en   = 1'b0;
    m_out_addr = '0;
`ifdef RF_WARB_RR_EN
    m_ptr      = 0;
`endif
    for (int k = 0; k < NUM_REQ; k++) v[k] = 1'b0;
  endtask

  // One clock cycle: check ready mid-cycle, predict, then check registered outputs after the edge.
  task automatic step();
    logic [NUM_REQ-1:0] g;
    wr_t  e;
    logic [31:0] pn;
    int   gk;
    @(negedge clk_i);
    g = model_grant();
    check("ready", 64'(req_ready_o), 64'(g));
    e.en = 1'b0; e.addr = '0; e.data = '0;
    gk = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (g[k]) begin
        gk = k;
        if (a[k] != '0) begin
          e.en = 1'b1; e.addr = a[k]; e.data = d[k];
        end
      end
    end
    exp_q.push_back(e);
    pn = m_pend;
    if (flush_i) pn = '0;
    else begin
      if (m_out_en) pn[m_out_addr] = 1'b0;
      if (issue_valid_i && issue_addr_i != '0) pn[issue_addr_i] = 1'b1;
    end
    @(posedge clk_i);
    #1;
    m_pend = pn;
    if (gk >= 0) begin
      v[gk] = 1'b0;
`ifdef RF_WARB_RR_EN
      m_ptr = (gk + 1) % NUM_REQ;
`endif
    end
    e = exp_q.pop_front();
    m_out_en = e.en;
    if (e.en) m_out_addr = e.addr;
    check("wr_en", 64'(rf_write_en_o), 64'(e.en));
    if (e.en) begin
      check("wr_addr", 64'(rf_write_addr_o), 64'(e.addr));
      check("wr_data", rf_write_data_o, e.data);
    end
    check("pending", 64'(pending_o), 64'(m_pend));
  endtask

  task automatic request(input int k, input logic [ADDR_W-1:0] addr, input logic [XLEN-1:0] data);
    v[k] = 1'b1;
    a[k] = addr;
    d[k] = data;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_i = 1'b0; flush_i = 1'b0; issue_valid_i = 1'b0; issue_addr_i = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v[k] = 1'b0; a[k] = '0; d[k] = '0;
    end
    model_reset();

    // Asynchronous reset mid-cycle, with a request already presented.
    request(2, 5'd3, 64'h1234);
    #2 rst_i = 1'b1;
    #1;
    check("rst_en",   64'(rf_write_en_o), 64'd0);
    check("rst_addr", 64'(rf_write_addr_o), 64'd0);
    check("rst_data", rf_write_data_o, 64'd0);
    check("rst_pend", 64'(pending_o), 64'd0);
    check("rst_ready", 64'(req_ready_o), 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    model_reset();
    step();                               // no spurious write after release

    // Single requester 1 to x5.
    request(1, 5'd5, 64'hDEAD);
    step();
    step();

    // All three valid continuously.
    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < NUM_REQ; k++)
        if (!v[k]) request(k, ADDR_W'(10 + k), 64'(n * 16 + k));
      step();
    end
    for (int k = 0; k < NUM_REQ; k++) v[k] = 1'b0;
    step();

    // Scoreboard set, clear on commit, and set winning over same-cycle clear.
    issue_valid_i = 1'b1; issue_addr_i = 5'd7;
    step();
    issue_valid_i = 1'b0;
    check("pend7_set", 64'(pending_o[7]), 64'd1);
    request(0, 5'd7, 64'h77);
    step();
    step();
    check("pend7_clr", 64'(pending_o[7]), 64'd0);
    issue_valid_i = 1'b1;
    step();
    issue_valid_i = 1'b0;
    request(0, 5'd7, 64'h78);
    step();
    issue_valid_i = 1'b1;                 // issue in the commit cycle
    step();
    issue_valid_i = 1'b0;
    check("pend7_setwins", 64'(pending_o[7]), 64'd1);

    // x0: consumed but never written; issue to x0 ignored.
    request(0, 5'd0, 64'h1);
    issue_valid_i = 1'b1; issue_addr_i = 5'd0;
    step();
    issue_valid_i = 1'b0;
    step();
    check("pend0", 64'(pending_o[0]), 64'd0);

    // Flush with pending = 0xF0, req2 waiting, prior write in the output register.
    for (int r = 4; r < 7; r++) begin
      issue_valid_i = 1'b1; issue_addr_i = ADDR_W'(r);
      step();
    end
    issue_valid_i = 1'b0;
    check("pend_pre_flush", 64'(pending_o), 64'hF0);
    request(0, 5'd3, 64'hC0FFEE);
    step();
    check("commit_before_flush", 64'(rf_write_en_o), 64'd1);
    request(2, 5'd12, 64'hBEEF);
    flush_i = 1'b1;
    issue_valid_i = 1'b1; issue_addr_i = 5'd9;
    step();
    flush_i = 1'b0;
    issue_valid_i = 1'b0;
    check("pend_flushed", 64'(pending_o), 64'd0);
    step();                               // req2 granted after the flush
    step();

    // Randomised traffic.
    for (int n = 0; n < 80; n++) begin
      for (int k = 0; k < NUM_REQ; k++)
        if (!v[k] && $urandom_range(0, 1) == 1)
          request(k, ADDR_W'($urandom_range(0, 31)), {$urandom, $urandom});
      issue_valid_i = ($urandom_range(0, 1) == 1);
      issue_addr_i  = ADDR_W'($urandom_range(0, 31));
      flush_i       = ($urandom_range(0, 15) == 0);
      step();
    end
    flush_i = 1'b0;
    issue_valid_i = 1'b0;

    // Reset mid-operation drops the in-flight write.
    request(1, 5'd9, 64'h99);
    step();
    #3 rst_i = 1'b1;
    #1;
    check("rst2_en", 64'(rf_write_en_o), 64'd0);
    check("rst2_pend", 64'(pending_o), 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    model_reset();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
